// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO head and sends each as an
// asynchronous serial frame (start, 8 data LSB first, optional parity, 1-2 stop).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_pop,
  output logic        txd,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic bit_end;
  logic frame_end;
  logic pop;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && (stop_idx_q == STOP_LAST);
  // Held low during reset so an idle FSM cannot drain the FIFO while rst is high.
  assign pop       = (state_q == S_IDLE) && en && !fifo_empty && !rst;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Next-state and bit-timing counters
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d    = S_START;
          baud_d     = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (frame_end)    state_d    = S_IDLE;
        else if (bit_end) stop_idx_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pop request, registered txd/busy/frame_done/frame_cnt, byte shifter
  always_comb begin
    fifo_pop     = pop;
    txd_d        = txd_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d  = fifo_dout;
          parity_d = (^fifo_dout) ^ (PARITY_ODD != 0);
          txd_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      // txd is registered, so each bit is loaded at the end of the previous one.
      S_START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            txd_d = (PARITY_EN != 0) ? parity_q : 1'b1;
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) txd_d = 1'b1;
      end
      S_STOP: begin
        if (frame_end) begin
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at
// 4 clocks per bit, each fed by a small FIFO model and checked by its own monitor.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  longint  cyc = 0;
  int      chk = 0;
  int      err = 0;

  always #5 clk = ~clk;

  // Cycle counter used to timestamp pops
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    localparam int L  = (1 + 8 + PE + SB) * C;
    localparam logic [63:0] MASK = (64'd1 << L) - 64'd1;

    logic        en = 1'b0;
    logic        fifo_empty, fifo_pop, txd, busy, frame_done;
    logic [7:0]  fifo_dout;
    logic [15:0] frame_cnt;
    logic [7:0]  mem [16];
    int unsigned wr = 0;
    int unsigned rd = 0;
    logic [8:0]  exp_q [$];
    longint      pop_cyc [$];
    int          chk = 0;
    int          err = 0;
    int unsigned pops = 0;
    int unsigned nfr = 0;
    int          cap = -1;
    logic [63:0] a_txd, a_busy, a_done, e_txd;
    logic [15:0] e_cnt;
    logic [8:0]  cur;

    assign fifo_empty = (wr == rd);
    assign fifo_dout  = mem[rd[3:0]];

    // FIFO model read pointer
    always @(posedge clk) if (fifo_pop) rd <= rd + 1;

    fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .PARITY_EN(PE),
      .PARITY_ODD(PO),
      .STOP_BITS(SB)
    ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout),
      .fifo_pop(fifo_pop),
      .txd(txd),
      .busy(busy),
      .frame_done(frame_done),
      .frame_cnt(frame_cnt)
    );

    // Monitor: capture each frame after a pop and compare with the expected entry
    always @(negedge clk or posedge rst) begin
      if (rst) begin
        cap   = -1;
        e_cnt = '0;
      end else begin
        if (cap >= 0 && cap < L) begin
          a_txd[cap]  = txd;
          a_busy[cap] = busy;
          a_done[cap] = frame_done;
          cap++;
        end else if (cap == L) begin
          e_cnt = e_cnt + 16'd1;
          nfr++;
          chk++;
          if (((a_txd ^ e_txd) & MASK) != 64'd0) begin
            err++;
            $display("FAIL u%0d txd_wave byte=%02h got=%h want=%h", g, cur[7:0], a_txd & MASK, e_txd & MASK);
          end
          chk++;
          if ((a_busy & MASK) != MASK) begin
            err++;
            $display("FAIL u%0d busy_wave got=%h want=%h", g, a_busy & MASK, MASK);
          end
          chk++;
          if ((a_done & MASK) != 64'd0) begin
            err++;
            $display("FAIL u%0d done_early got=%h want=0", g, a_done & MASK);
          end
          chk++;
          if (frame_done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            err++;
            $display("FAIL u%0d end_state done/busy/txd got=%b%b%b want=101", g, frame_done, busy, txd);
          end
          chk++;
          if (frame_cnt !== e_cnt) begin
            err++;
            $display("FAIL u%0d frame_cnt got=%0d want=%0d", g, frame_cnt, e_cnt);
          end
          cap = -1;
        end
        if (fifo_pop) begin
          chk++;
          if (fifo_empty || !en || cap != -1) begin
            err++;
            $display("FAIL u%0d pop_illegal empty/en/capturing got=%b%b%b want=010", g, fifo_empty, en, cap != -1);
          end
          pops++;
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk++;
            err++;
            $display("FAIL u%0d unexpected_pop got=pop want=none", g);
            cap = -1;
          end else begin
            cur = exp_q.pop_front();
            e_txd = '1;
            for (int i = 0; i < L; i++) begin
              int b;
              b = i / C;
              if (b == 0)                 e_txd[i] = 1'b0;
              else if (b <= 8)            e_txd[i] = cur[b-1];
              else if (PE != 0 && b == 9) e_txd[i] = cur[8];
              else                        e_txd[i] = 1'b1;
            end
            a_txd  = '0;
            a_busy = '0;
            a_done = '0;
            cap    = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] v, input logic p);
    case (k)
      0: begin u[0].mem[u[0].wr[3:0]] = v; u[0].exp_q.push_back({p, v}); u[0].wr++; end
      1: begin u[1].mem[u[1].wr[3:0]] = v; u[1].exp_q.push_back({p, v}); u[1].wr++; end
      2: begin u[2].mem[u[2].wr[3:0]] = v; u[2].exp_q.push_back({p, v}); u[2].wr++; end
      default: begin u[3].mem[u[3].wr[3:0]] = v; u[3].exp_q.push_back({p, v}); u[3].wr++; end
    endcase
  endtask

  task automatic set_en(input int k, input logic v);
    case (k)
      0: u[0].en = v;
      1: u[1].en = v;
      2: u[2].en = v;
      default: u[3].en = v;
    endcase
  endtask

  function automatic int unsigned nfr_of(input int k);
    case (k)
      0: return u[0].nfr;
      1: return u[1].nfr;
      2: return u[2].nfr;
      default: return u[3].nfr;
    endcase
  endfunction

  function automatic int unsigned pops_of(input int k);
    case (k)
      0: return u[0].pops;
      1: return u[1].pops;
      2: return u[2].pops;
      default: return u[3].pops;
    endcase
  endfunction

  // Distance in cycles between pop n-1-j and pop n-2-j
  function automatic longint gap_of(input int k, input int j);
    longint a, b;
    int n;
    a = 0;
    b = 0;
    case (k)
      0: begin n = u[0].pop_cyc.size(); if (n >= j + 2) begin a = u[0].pop_cyc[n-1-j]; b = u[0].pop_cyc[n-2-j]; end end
      1: begin n = u[1].pop_cyc.size(); if (n >= j + 2) begin a = u[1].pop_cyc[n-1-j]; b = u[1].pop_cyc[n-2-j]; end end
      2: begin n = u[2].pop_cyc.size(); if (n >= j + 2) begin a = u[2].pop_cyc[n-1-j]; b = u[2].pop_cyc[n-2-j]; end end
      default: begin n = u[3].pop_cyc.size(); if (n >= j + 2) begin a = u[3].pop_cyc[n-1-j]; b = u[3].pop_cyc[n-2-j]; end end
    endcase
    return a - b;
  endfunction

  task automatic check_val(input string tag, input longint got, input longint want);
    chk++;
    if (got != want) begin
      err++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic wait_frames(input int k, input int unsigned n, input string tag);
    int unsigned t = 0;
    while (nfr_of(k) < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_frames_done"}, longint'(nfr_of(k)), longint'(n));
    step();
  endtask

  task automatic wait_pops(input int k, input int unsigned n, input string tag);
    int unsigned t = 0;
    while (pops_of(k) < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_pop_seen"}, longint'(pops_of(k)), longint'(n));
  endtask

  initial begin
    int unsigned nf;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    // Reset state
    check_val("rst_txd",        longint'(u[0].txd),        1);
    check_val("rst_busy",       longint'(u[0].busy),       0);
    check_val("rst_frame_done", longint'(u[0].frame_done), 0);
    check_val("rst_frame_cnt",  longint'(u[0].frame_cnt),  0);
    check_val("rst_fifo_pop",   longint'(u[0].fifo_pop),   0);
    rst = 1'b0;
    step();

    // 8N1 single byte
    push(0, 8'hA5, 1'b0);
    set_en(0, 1'b1);
    wait_frames(0, 1, "t1");
    check_val("t1_pop_count", longint'(pops_of(0)), 1);
    check_val("t1_frame_cnt", longint'(u[0].frame_cnt), 1);

    // Three queued bytes back to back
    push(0, 8'h01, 1'b0);
    push(0, 8'h80, 1'b0);
    push(0, 8'hFF, 1'b0);
    wait_frames(0, 4, "t2");
    check_val("t2_gap_a", gap_of(0, 1), 41);
    check_val("t2_gap_b", gap_of(0, 0), 41);
    repeat (10) step();
    check_val("t2_no_pop_empty", longint'(pops_of(0)), 4);
    check_val("t2_frame_cnt", longint'(u[0].frame_cnt), 4);

    // Parity: even on u1, odd on u2
    push(1, 8'h07, 1'b1);
    push(1, 8'h00, 1'b0);
    set_en(1, 1'b1);
    wait_frames(1, 2, "t3e");
    check_val("t3_even_gap", gap_of(1, 0), 45);
    push(2, 8'h07, 1'b0);
    set_en(2, 1'b1);
    wait_frames(2, 1, "t3o");

    // Two stop bits
    push(3, 8'h55, 1'b0);
    push(3, 8'hAA, 1'b0);
    set_en(3, 1'b1);
    wait_frames(3, 2, "t4");
    check_val("t4_gap", gap_of(3, 0), 45);

    // en gating
    set_en(0, 1'b0);
    push(0, 8'h3C, 1'b0);
    push(0, 8'h96, 1'b0);
    push(0, 8'hC3, 1'b0);
    repeat (20) step();
    check_val("t5_no_pop_en0", longint'(pops_of(0)), 4);
    check_val("t5_txd_idle", longint'(u[0].txd), 1);
    set_en(0, 1'b1);
    wait_pops(0, 5, "t5");
    step();
    set_en(0, 1'b0);
    wait_frames(0, 5, "t5");
    repeat (20) step();
    check_val("t5_no_pop_after_drop", longint'(pops_of(0)), 5);
    check_val("t5_busy_idle", longint'(u[0].busy), 0);

    // Reset during data bit 3 of 0x96 (bit 3 = 0)
    set_en(0, 1'b1);
    wait_pops(0, 6, "t6");
    repeat (18) @(posedge clk);
    #1;
    check_val("t6_txd_bit3", longint'(u[0].txd), 0);
    rst = 1'b1;
    #1;
    check_val("t6_rst_txd",       longint'(u[0].txd),       1);
    check_val("t6_rst_busy",      longint'(u[0].busy),      0);
    check_val("t6_rst_frame_cnt", longint'(u[0].frame_cnt), 0);
    check_val("t6_rst_pop",       longint'(u[0].fifo_pop),  0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    nf = nfr_of(0);
    wait_frames(0, nf + 1, "t6");
    check_val("t6_frame_cnt", longint'(u[0].frame_cnt), 1);
    check_val("t6_pop_count", longint'(pops_of(0)), 7);

    $display("Simulation finished: %0d checks, %0d errors",
             chk + u[0].chk + u[1].chk + u[2].chk + u[3].chk,
             err + u[0].err + u[1].err + u[2].err + u[3].err);
    $finish;
  end

endmodule
